// File: rtl/div_arb_pkg.sv
// Shared types, constants and the round-robin pick used by the divider arbiter.
`default_nettype none

package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } div_arb_state_t;

  localparam int MAX_REQ             = 32;
  localparam int REQ_IDX_W           = $clog2(MAX_REQ);
  localparam int DIV_LATENCY_DEFAULT = 66;

  // Returns {found, index} of the first set bit at or after ptr, wrapping at n.
  function automatic logic [REQ_IDX_W:0] rr_select(input logic [MAX_REQ-1:0] valid,
                                                   input int n, input int ptr);
    logic                 found;
    logic [REQ_IDX_W-1:0] idx;
    int                   j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = ptr + k;
      if (j >= n) j = j - n;
      if (k < n && !found) begin
        if (valid[j[REQ_IDX_W-1:0]]) begin
          found = 1'b1;
          idx   = j[REQ_IDX_W-1:0];
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

`default_nettype wire

// File: rtl/divider2.sv
// Blocking unsigned restoring divider: one quotient bit per cycle, results stable WIDTH+1 cycles after start.
`default_nettype none

module divider2 #(
  parameter int WIDTH = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             data_valid_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // diff MSB set means the trial subtraction borrowed (shifted < divisor).
  assign shifted = {acc, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (data_valid_in) begin
      acc <= '0;
      quo <= dividend_in;
      dvs <= divisor_in;
      cnt <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (diff[WIDTH]) begin
        acc <= shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end else begin
        acc <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end
    end
  end

  assign quotient_out  = quo;
  assign remainder_out = acc;

endmodule

`default_nettype wire

// File: rtl/div_arbiter.sv
// Round-robin arbiter that time-shares one blocking divider2 among N_REQ requesters.
`default_nettype none

module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int N_REQ       = 2,
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [N_REQ-1:0]            req_valid_in,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_dividend_in,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_divisor_in,
  output logic [N_REQ-1:0]            req_ready_out,
  output logic [N_REQ-1:0]            resp_valid_out,
  output logic [WIDTH-1:0]            quotient_out,
  output logic [WIDTH-1:0]            remainder_out,
  output logic                        div_by_zero_out,
  output logic                        busy_out
);

  localparam int CNT_W = $clog2(DIV_LATENCY);

  div_arb_state_t       state;
  logic [REQ_IDX_W-1:0] rr_ptr;
  logic [REQ_IDX_W-1:0] owner;
  logic [WIDTH-1:0]     dvd;
  logic [WIDTH-1:0]     dvs;
  logic [CNT_W-1:0]     cnt;
  logic [MAX_REQ-1:0]   valid_ext;
  logic [REQ_IDX_W:0]   pick;
  logic                 sel_found;
  logic [REQ_IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0]     div_q;
  logic [WIDTH-1:0]     div_r;

  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = req_valid_in;
  end

  assign pick      = rr_select(valid_ext, N_REQ, int'(rr_ptr));
  assign sel_found = pick[REQ_IDX_W];
  assign sel_idx   = pick[REQ_IDX_W-1:0];

  always_comb begin
    req_ready_out = '0;
    if (state == IDLE && sel_found) req_ready_out[sel_idx] = 1'b1;
  end

  assign busy_out = (state != IDLE);

  divider2 #(.WIDTH(WIDTH)) u_divider2 (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_valid_in (state == ISSUE),
    .dividend_in   (dvd),
    .divisor_in    (dvs),
    .quotient_out  (div_q),
    .remainder_out (div_r)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      owner           <= '0;
      dvd             <= '0;
      dvs             <= '0;
      cnt             <= '0;
      resp_valid_out  <= '0;
      quotient_out    <= '0;
      remainder_out   <= '0;
      div_by_zero_out <= 1'b0;
    end else begin
      resp_valid_out <= '0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            dvd    <= req_dividend_in[sel_idx];
            dvs    <= req_divisor_in[sel_idx];
            owner  <= sel_idx;
            rr_ptr <= (int'(sel_idx) == N_REQ - 1) ? '0 : sel_idx + 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_W'(DIV_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            // A zero divisor still runs the full latency; only the result is overridden.
            if (dvs == '0) begin
              quotient_out    <= '1;
              remainder_out   <= dvd;
              div_by_zero_out <= 1'b1;
            end else begin
              quotient_out    <= div_q;
              remainder_out   <= div_r;
              div_by_zero_out <= 1'b0;
            end
            resp_valid_out[owner] <= 1'b1;
            state                 <= RESPOND;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with three requesters and directed division vectors.
`default_nettype none

module tb_div_arbiter;

  localparam int W  = 64;
  localparam int NR = 3;
  localparam int LAT = 66;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     valid = '0;
  logic [NR-1:0][W-1:0] dvd = '0;
  logic [NR-1:0][W-1:0] dvs = '0;
  logic [NR-1:0]     ready;
  logic [NR-1:0]     resp;
  logic [W-1:0]      q;
  logic [W-1:0]      r;
  logic              dbz;
  logic              busy;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         owner;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       dbz;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  div_arbiter #(.WIDTH(W), .N_REQ(NR), .DIV_LATENCY(LAT)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .req_valid_in    (valid),
    .req_dividend_in (dvd),
    .req_divisor_in  (dvs),
    .req_ready_out   (ready),
    .resp_valid_out  (resp),
    .quotient_out    (q),
    .remainder_out   (r),
    .div_by_zero_out (dbz),
    .busy_out        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int owner, input logic [W-1:0] eq, input logic [W-1:0] er,
                      input logic edbz, input int ecyc);
    exp_t e;
    e.owner = owner; e.q = eq; e.r = er; e.dbz = edbz; e.cyc = ecyc;
    sb.push_back(e);
  endtask

  // Monitor: every response strobe is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", W'(resp), '0);
        end else begin
          e = sb.pop_front();
          chk("resp_owner", W'(resp), W'(1) << e.owner);
          chk("resp_quotient", q, e.q);
          chk("resp_remainder", r, e.r);
          chk("resp_dbz", W'(dbz), W'(e.dbz));
          chk("resp_cycle", W'(cyc), W'(e.cyc));
        end
      end
    end
  end

  task automatic wait_idle();
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                      input bit hold, input bit do_push, output int a_cyc);
    bit got = 0;
    valid[idx] = 1'b1; dvd[idx] = a; dvs[idx] = b;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (ready[idx]) got = 1;
    end
    a_cyc = cyc;
    if (!got) begin
      total++; bad++;
      $display("FAIL grant_timeout req=%0d actual=no_ready required=ready", idx);
    end else begin
      chk("grant_onehot", W'(ready), W'(1) << idx);
      if (do_push) push(idx, eq, er, edbz, cyc + LAT + 2);
    end
    @(posedge clk); #1;
    if (!hold) valid[idx] = 1'b0;
  endtask

  initial begin
    int a, b0, s, rel;
    bit got;

    // Reset state.
    @(negedge clk);
    chk("rst_ready", W'(ready), '0);
    chk("rst_resp", W'(resp), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_dbz", W'(dbz), '0);
    chk("rst_quotient", q, '0);
    chk("rst_remainder", r, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single divide.
    send(0, 1000, 7, 142, 6, 0, 0, 1, a);
    wait_idle();

    // Round robin: lone request, then two contenders.
    send(0, 9, 3, 3, 0, 0, 0, 1, a);
    wait_idle();
    valid[1] = 1'b1; dvd[1] = 20; dvs[1] = 6;
    valid[0] = 1'b1; dvd[0] = 8;  dvs[0] = 2;
    @(negedge clk);
    b0 = cyc;
    chk("rr_first_grant", W'(ready), W'(3'b010));
    push(1, 3, 2, 0, b0 + 68);
    push(0, 4, 0, 0, b0 + 137);
    @(posedge clk); #1;
    valid[1] = 1'b0;
    got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (ready[0]) got = 1;
    end
    chk("rr_second_grant_cycle", W'(cyc), W'(b0 + 69));
    chk("rr_busy_in_idle", W'(busy), '0);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    wait_idle();

    // Divide by zero, then a normal divide.
    send(0, 55, 0, 64'hFFFF_FFFF_FFFF_FFFF, 55, 1, 0, 1, a);
    wait_idle();
    send(1, 4, 2, 2, 0, 0, 0, 1, a);
    wait_idle();

    // Saturation from a fresh pointer: all three requesters continuously valid.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    valid = 3'b111;
    dvd[0] = 10;  dvs[0] = 3;
    dvd[1] = 100; dvs[1] = 9;
    dvd[2] = 7;   dvs[2] = 7;
    for (int t = 0; t <= 345; t++) begin
      @(negedge clk);
      if (t == 0) begin
        s = cyc;
        for (int k = 0; k < 6; k++) begin
          case (k % 3)
            0: push(0, 3, 1, 0, s + 68 + 69 * k);
            1: push(1, 11, 1, 0, s + 68 + 69 * k);
            default: push(2, 1, 0, 0, s + 68 + 69 * k);
          endcase
        end
      end
      if (t % 69 == 0) begin
        chk("sat_ready", W'(ready), W'(1) << ((t / 69) % 3));
        chk("sat_busy_idle", W'(busy), '0);
      end else if (t % 23 == 0) begin
        chk("sat_ready_busy", W'(ready), '0);
        chk("sat_busy", W'(busy), W'(1));
      end
    end
    @(posedge clk); #1;
    valid = '0;
    wait_idle();

    // Withdrawal by requester 1, hold-through-response by requester 0.
    send(0, 12, 4, 3, 0, 0, 1, 1, a);
    repeat (9) @(posedge clk);
    #1;
    valid[1] = 1'b1; dvd[1] = 1; dvs[1] = 1;
    @(negedge clk);
    chk("wd_ready_while_busy", W'(ready), '0);
    repeat (10) @(posedge clk);
    #1;
    valid[1] = 1'b0;
    for (int k = 0; k < 100 && cyc < a + 69; k++) @(negedge clk);
    chk("hold_regrant", W'(ready), W'(3'b001));
    chk("hold_regrant_cycle", W'(cyc), W'(a + 69));
    push(0, 3, 0, 0, a + 69 + 68);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    wait_idle();

    // Reset during WAIT discards the operation.
    send(0, 500, 5, 100, 0, 0, 0, 0, a);
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready", W'(ready), '0);
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_quotient", q, '0);
    chk("midrst_remainder", r, '0);
    chk("midrst_dbz", W'(dbz), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    rel = cyc;
    send(0, 100, 10, 10, 0, 0, 0, 1, a);
    chk("post_rst_grant_cycle", W'(a), W'(rel));
    wait_idle();

    repeat (5) @(negedge clk);
    chk("sb_empty", W'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
